// File: rtl/mem_lsu_bus.sv
// Purpose : memory-stage load/store unit; turns execute-stage memory commands into word bus requests.
// Latency : request in the issue cycle; write-back one cycle after grant (stores) or after rvalid (loads).
// Backpress: stall_out holds upstream from the issue cycle until WB; bus_req_out held stable until grant.
//
// Ports:
//   clk_in, reset_in (async, active-low)
//   mem_op/addr/data/we_in           : memory command from execute
//   reg_waddr/wdata/we_in            : write-back from execute (passed through on non-memory ops)
//   bus_req/addr/we/be/wdata_out     : word-aligned bus request; bus_gnt_in accepts it
//   bus_rvalid_in, bus_rdata_in      : read response
//   stall_out, reg_we/waddr/wdata_out: pipeline hold and register write-back
//   misalign_out                     : one-cycle misaligned-access flag
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and flag misalign_out.

`ifndef MEM_NOP
`define MEM_NOP 4'd0
`define LB      4'd1
`define LBU     4'd2
`define LH      4'd3
`define LHU     4'd4
`define LW      4'd5
`define SB      4'd6
`define SH      4'd7
`define SW      4'd8
`endif

module mem_lsu_bus #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_in,
   input  logic                  reset_in,
   input  logic [3:0]            mem_op_in,
   input  logic [ADDR_WIDTH-1:0] mem_addr_in,
   input  logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic                  mem_we_in,
   input  logic [4:0]            reg_waddr_in,
   input  logic [DATA_WIDTH-1:0] reg_wdata_in,
   input  logic                  reg_we_in,
   output logic                  bus_req_out,
   output logic [ADDR_WIDTH-1:0] bus_addr_out,
   output logic                  bus_we_out,
   output logic [3:0]            bus_be_out,
   output logic [DATA_WIDTH-1:0] bus_wdata_out,
   input  logic                  bus_gnt_in,
   input  logic                  bus_rvalid_in,
   input  logic [DATA_WIDTH-1:0] bus_rdata_in,
   output logic                  stall_out,
   output logic                  reg_we_out,
   output logic [4:0]            reg_waddr_out,
   output logic [DATA_WIDTH-1:0] reg_wdata_out,
   output logic                  misalign_out
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RWAIT, S_WB} state_t;

   function automatic logic op_is_load(input logic [3:0] op);
      return (op == `LB) || (op == `LBU) || (op == `LH) || (op == `LHU) || (op == `LW);
   endfunction

   function automatic logic op_is_store(input logic [3:0] op);
      return (op == `SB) || (op == `SH) || (op == `SW);
   endfunction

   // Halfword lane is chosen by a[1] only; words always use all lanes.
   function automatic logic [3:0] calc_be(input logic [3:0] op, input logic [1:0] a);
      case (op)
         `SB:     calc_be = 4'b0001 << a;
         `SH:     calc_be = a[1] ? 4'b1100 : 4'b0011;
         default: calc_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [DATA_WIDTH-1:0] calc_wdata(input logic [3:0] op, input logic [DATA_WIDTH-1:0] d);
      case (op)
         `SB:     calc_wdata = {4{d[7:0]}};
         `SH:     calc_wdata = {2{d[15:0]}};
         default: calc_wdata = d;
      endcase
   endfunction

   function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [3:0] op, input logic [1:0] a,
                                                      input logic [DATA_WIDTH-1:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{a, 3'b000} +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      case (op)
         `LB:     load_ext = {{24{b[7]}}, b};
         `LBU:    load_ext = {24'd0, b};
         `LH:     load_ext = {{16{h[15]}}, h};
         `LHU:    load_ext = {16'd0, h};
         default: load_ext = w;
      endcase
   endfunction

   state_t                  state_q, state_d;
   logic [3:0]              op_q, op_d;
   logic [1:0]              a_q, a_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    we_q, we_d;
   logic [3:0]              be_q, be_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [4:0]              waddr_q, waddr_d;
   logic                    reg_we_q, reg_we_d;
   logic [4:0]              reg_waddr_q, reg_waddr_d;
   logic [DATA_WIDTH-1:0]   reg_wdata_q, reg_wdata_d;
   logic                    misalign_q, misalign_d;

   logic                    idle, issue, trap, bus_req, stall, take_rdata;
   logic [3:0]              cur_op;
   logic [1:0]              cur_a;
   logic [4:0]              cur_waddr;
   logic [ADDR_WIDTH-1:0]   iss_addr;
   logic [3:0]              iss_be;
   logic [DATA_WIDTH-1:0]   iss_wdata;
   logic                    iss_we;

   // The op decode alone decides direction; the execute-stage write flag is redundant.
   logic unused_mem_we;
   assign unused_mem_we = mem_we_in;

   assign idle      = (state_q == S_IDLE);
   // Gating with reset_in keeps the combinational request path quiet while reset is held.
   assign issue     = idle && reset_in && (op_is_load(mem_op_in) || op_is_store(mem_op_in));
   assign cur_op    = idle ? mem_op_in : op_q;
   assign cur_a     = idle ? mem_addr_in[1:0] : a_q;
   assign cur_waddr = idle ? reg_waddr_in : waddr_q;
   assign iss_addr  = {mem_addr_in[ADDR_WIDTH-1:2], 2'b00};
   assign iss_be    = calc_be(mem_op_in, mem_addr_in[1:0]);
   assign iss_wdata = calc_wdata(mem_op_in, mem_data_in);
   assign iss_we    = op_is_store(mem_op_in);

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = (((mem_op_in == `LH) || (mem_op_in == `LHU) || (mem_op_in == `SH)) && mem_addr_in[0]) ||
                 (((mem_op_in == `LW) || (mem_op_in == `SW)) && (mem_addr_in[1:0] != 2'b00));
`else
   assign trap = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      addr_d      = addr_q;
      we_d        = we_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      waddr_d     = waddr_q;
      reg_we_d    = 1'b0;
      reg_waddr_d = reg_waddr_q;
      reg_wdata_d = reg_wdata_q;
      misalign_d  = 1'b0;
      bus_req     = 1'b0;
      stall       = 1'b0;
      take_rdata  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (issue) begin
               op_d    = mem_op_in;
               a_d     = mem_addr_in[1:0];
               addr_d  = iss_addr;
               we_d    = iss_we;
               be_d    = iss_be;
               wdata_d = iss_wdata;
               waddr_d = reg_waddr_in;
               stall   = 1'b1;
               if (trap) begin
                  state_d    = S_WB;
                  misalign_d = 1'b1;
               end else begin
                  bus_req = 1'b1;
                  state_d = S_REQ;
               end
            end else begin
               reg_we_d    = reg_we_in;
               reg_waddr_d = reg_waddr_in;
               reg_wdata_d = reg_wdata_in;
            end
         end
         S_REQ: begin
            bus_req = 1'b1;
            stall   = 1'b1;
         end
         S_RWAIT: begin
            stall = 1'b1;
            if (bus_rvalid_in) begin
               take_rdata = 1'b1;
               state_d    = S_WB;
            end
         end
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // A grant can land in the issue cycle or any REQ cycle; a load may see its data in that same cycle.
      if (bus_req && bus_gnt_in) begin
         if (!op_is_load(cur_op)) begin
            state_d = S_WB;
         end else if (bus_rvalid_in) begin
            take_rdata = 1'b1;
            state_d    = S_WB;
         end else begin
            state_d = S_RWAIT;
         end
      end
      if (take_rdata) begin
         reg_we_d    = 1'b1;
         reg_waddr_d = cur_waddr;
         reg_wdata_d = load_ext(cur_op, cur_a, bus_rdata_in);
      end
   end

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         state_q     <= S_IDLE;
         op_q        <= `MEM_NOP;
         a_q         <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         be_q        <= '0;
         wdata_q     <= '0;
         waddr_q     <= '0;
         reg_we_q    <= 1'b0;
         reg_waddr_q <= '0;
         reg_wdata_q <= '0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         waddr_q     <= waddr_d;
         reg_we_q    <= reg_we_d;
         reg_waddr_q <= reg_waddr_d;
         reg_wdata_q <= reg_wdata_d;
         misalign_q  <= misalign_d;
      end
   end

   assign bus_req_out   = bus_req;
   assign bus_addr_out  = !bus_req ? '0 : (idle ? iss_addr  : addr_q);
   assign bus_we_out    = bus_req && (idle ? iss_we : we_q);
   assign bus_be_out    = !bus_req ? '0 : (idle ? iss_be    : be_q);
   assign bus_wdata_out = !bus_req ? '0 : (idle ? iss_wdata : wdata_q);
   assign stall_out     = stall;
   assign reg_we_out    = reg_we_q;
   assign reg_waddr_out = reg_waddr_q;
   assign reg_wdata_out = reg_wdata_q;
   assign misalign_out  = misalign_q;

endmodule

// File: tb/tb_mem_lsu_bus.sv
// Bench for mem_lsu_bus: directed scenarios plus randomized transactions checked against a
// behavioural model of the access rules (lanes, byte enables, extension, write-back timing).

`ifndef MEM_NOP
`define MEM_NOP 4'd0
`define LB      4'd1
`define LBU     4'd2
`define LH      4'd3
`define LHU     4'd4
`define LW      4'd5
`define SB      4'd6
`define SH      4'd7
`define SW      4'd8
`endif

module tb_mem_lsu_bus;
   logic        clk_in = 1'b0;
   logic        reset_in;
   logic [3:0]  mem_op_in;
   logic [31:0] mem_addr_in, mem_data_in;
   logic        mem_we_in;
   logic [4:0]  reg_waddr_in;
   logic [31:0] reg_wdata_in;
   logic        reg_we_in;
   logic        bus_req_out, bus_we_out, bus_gnt_in, bus_rvalid_in;
   logic [31:0] bus_addr_out, bus_wdata_out, bus_rdata_in;
   logic [3:0]  bus_be_out;
   logic        stall_out, reg_we_out, misalign_out;
   logic [4:0]  reg_waddr_out;
   logic [31:0] reg_wdata_out;

   int errors = 0;
   int checks = 0;

   always #5 clk_in = ~clk_in;

   mem_lsu_bus #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk_in(clk_in), .reset_in(reset_in),
      .mem_op_in(mem_op_in), .mem_addr_in(mem_addr_in), .mem_data_in(mem_data_in), .mem_we_in(mem_we_in),
      .reg_waddr_in(reg_waddr_in), .reg_wdata_in(reg_wdata_in), .reg_we_in(reg_we_in),
      .bus_req_out(bus_req_out), .bus_addr_out(bus_addr_out), .bus_we_out(bus_we_out),
      .bus_be_out(bus_be_out), .bus_wdata_out(bus_wdata_out),
      .bus_gnt_in(bus_gnt_in), .bus_rvalid_in(bus_rvalid_in), .bus_rdata_in(bus_rdata_in),
      .stall_out(stall_out), .reg_we_out(reg_we_out), .reg_waddr_out(reg_waddr_out),
      .reg_wdata_out(reg_wdata_out), .misalign_out(misalign_out)
   );

   // ---------------- reference model ----------------
   function automatic bit m_is_load(input logic [3:0] op);
      return (op >= `LB) && (op <= `LW);
   endfunction

   function automatic bit m_trap(input logic [3:0] op, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
      int a = int'(addr % 4);
      if (op == `LH || op == `LHU || op == `SH) return (a % 2) == 1;
      if (op == `LW || op == `SW) return a != 0;
      return 1'b0;
`else
      return (op == 4'hF) && (addr == 32'h0) && 1'b0;
`endif
   endfunction

   function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] addr);
      int a = int'(addr % 4);
      if (op == `SB) return 4'(1 << a);
      if (op == `SH) return 4'(3 << (2 * (a / 2)));
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wd(input logic [3:0] op, input logic [31:0] d);
      if (op == `SB) return (d & 32'hFF) * 32'h0101_0101;
      if (op == `SH) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] m_result(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] w);
      int unsigned a = addr % 4;
      int unsigned b = (w >> (8 * a)) & 32'hFF;
      int unsigned h = (w >> (16 * (a / 2))) & 32'hFFFF;
      case (op)
         `LB:     return (b >= 128) ? b - 256 : b;
         `LBU:    return b;
         `LH:     return (h >= 32768) ? h - 65536 : h;
         `LHU:    return h;
         default: return w;
      endcase
   endfunction

   // One transaction; gnt arrives gdly cycles after issue, rvalid rdly cycles after grant.
   // Returns at the write-back cycle with a NOP already on the command inputs.
   task automatic run_txn(input string nm, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] wa,
                          input int gdly, input int rdly, input logic [31:0] rdata);
      bit          ld, trap, e_req;
      int          wb_cyc;
      logic [31:0] e_addr, e_wd, e_res;
      logic [3:0]  e_be;
      ld     = m_is_load(op);
      trap   = m_trap(op, addr);
      wb_cyc = trap ? 1 : (ld ? gdly + rdly + 1 : gdly + 1);
      e_addr = addr - (addr % 4);
      e_be   = m_be(op, addr);
      e_wd   = m_wd(op, data);
      e_res  = m_result(op, addr, rdata);
      @(negedge clk_in);
      mem_op_in    = op;
      mem_addr_in  = addr;
      mem_data_in  = data;
      mem_we_in    = 1'($urandom);
      reg_waddr_in = wa;
      reg_we_in    = 1'($urandom);
      reg_wdata_in = $urandom;
      bus_rdata_in = rdata;
      for (int cyc = 0; cyc <= wb_cyc; cyc++) begin
         bus_gnt_in    = !trap && (cyc == gdly);
         bus_rvalid_in = ld && !trap && (cyc == gdly + rdly);
         #1;
         e_req = !trap && (cyc <= gdly);
         checks++;
         if (bus_req_out !== e_req) begin
            errors++; $display("FAIL %s cyc%0d bus_req got %b want %b", nm, cyc, bus_req_out, e_req);
         end
         if (e_req) begin
            checks++;
            if (bus_addr_out !== e_addr || bus_be_out !== e_be || bus_we_out !== !ld) begin
               errors++;
               $display("FAIL %s cyc%0d bus addr/be/we got %h/%b/%b want %h/%b/%b",
                        nm, cyc, bus_addr_out, bus_be_out, bus_we_out, e_addr, e_be, !ld);
            end
            if (!ld) begin
               checks++;
               if (bus_wdata_out !== e_wd) begin
                  errors++; $display("FAIL %s cyc%0d wdata got %h want %h", nm, cyc, bus_wdata_out, e_wd);
               end
            end
         end
         if (cyc < wb_cyc) begin
            checks++;
            if (stall_out !== 1'b1) begin
               errors++; $display("FAIL %s cyc%0d stall got %b want 1", nm, cyc, stall_out);
            end
            if (cyc > 0) begin
               checks++;
               if (reg_we_out !== 1'b0) begin
                  errors++; $display("FAIL %s cyc%0d early reg_we got %b want 0", nm, cyc, reg_we_out);
               end
            end
            @(negedge clk_in);
         end else begin
            checks++;
            if (stall_out !== 1'b0 || reg_we_out !== (ld && !trap) || misalign_out !== trap) begin
               errors++;
               $display("FAIL %s wb stall/reg_we/misalign got %b/%b/%b want 0/%b/%b",
                        nm, stall_out, reg_we_out, misalign_out, ld && !trap, trap);
            end
            if (ld && !trap) begin
               checks++;
               if (reg_wdata_out !== e_res || reg_waddr_out !== wa) begin
                  errors++;
                  $display("FAIL %s wb data/waddr got %h/%0d want %h/%0d", nm, reg_wdata_out, reg_waddr_out, e_res, wa);
               end
            end
            mem_op_in = `MEM_NOP;
            reg_we_in = 1'b0;
         end
      end
   endtask

   task automatic test_reset;
      reset_in = 1'b0;
      mem_op_in = `MEM_NOP; mem_addr_in = 0; mem_data_in = 0; mem_we_in = 0;
      reg_waddr_in = 0; reg_wdata_in = 0; reg_we_in = 0;
      bus_gnt_in = 0; bus_rvalid_in = 0; bus_rdata_in = 0;
      @(negedge clk_in); @(negedge clk_in); #1;
      checks++;
      if ({bus_req_out, bus_addr_out, bus_we_out, bus_be_out, bus_wdata_out, stall_out,
           reg_we_out, reg_waddr_out, reg_wdata_out, misalign_out} !== '0) begin
         errors++; $display("FAIL reset outputs nonzero req=%b be=%b stall=%b reg_we=%b want all 0",
                            bus_req_out, bus_be_out, stall_out, reg_we_out);
      end
      @(negedge clk_in);
      reset_in = 1'b1;
   endtask

   task automatic test_nop_passthrough;
      logic [4:0]  pa;
      logic [31:0] pd;
      logic        pw;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_in);
         mem_op_in = (i % 2 == 0) ? `MEM_NOP : 4'(9 + $urandom_range(6, 0));
         mem_we_in = 1'($urandom);
         #1;
         checks++;
         if (bus_req_out !== 1'b0 || stall_out !== 1'b0) begin
            errors++; $display("FAIL nop%0d req/stall got %b/%b want 0/0", i, bus_req_out, stall_out);
         end
         if (i > 0) begin
            checks++;
            if (reg_we_out !== pw || reg_waddr_out !== pa || reg_wdata_out !== pd) begin
               errors++; $display("FAIL nop%0d passthrough got %b/%0d/%h want %b/%0d/%h",
                                  i, reg_we_out, reg_waddr_out, reg_wdata_out, pw, pa, pd);
            end
         end
         pw = 1'($urandom); pa = 5'($urandom); pd = $urandom;
         reg_we_in = pw; reg_waddr_in = pa; reg_wdata_in = pd;
      end
      @(negedge clk_in);
      mem_op_in = `MEM_NOP; reg_we_in = 1'b0;
   endtask

   task automatic test_store_byte;
      run_txn("sb_1003", `SB, 32'h1003, 32'h0000_00A5, 5'd3, 0, 0, 32'h0);
      run_txn("sh_hi",   `SH, 32'h1002, 32'h1234_5678, 5'd4, 1, 0, 32'h0);
      run_txn("sw",      `SW, 32'h1008, 32'hDEAD_BEEF, 5'd5, 2, 0, 32'h0);
   endtask

   task automatic test_load_byte;
      run_txn("lb_2001",  `LB,  32'h2001, 32'h0, 5'd7,  0, 1, 32'h0000_8000);
      run_txn("lbu_2003", `LBU, 32'h2003, 32'h0, 5'd8,  0, 2, 32'h9A00_0000);
   endtask

   task automatic test_lhu_gnt_delay;
      run_txn("lhu_2002", `LHU, 32'h2002, 32'h0, 5'd9,  3, 1, 32'hBEEF_1234);
      run_txn("lh_2000",  `LH,  32'h2000, 32'h0, 5'd10, 1, 3, 32'h0000_8001);
   endtask

   task automatic test_lw_same_cycle;
      run_txn("lw_same0", `LW, 32'h2004, 32'h0, 5'd11, 0, 0, 32'h8765_4321);
      run_txn("lw_same2", `LW, 32'h2008, 32'h0, 5'd12, 2, 0, 32'hFFFF_0001);
   endtask

   task automatic test_misalign;
      run_txn("lw_3002", `LW, 32'h3002, 32'h0,       5'd13, 0, 1, 32'hCAFE_F00D);
      run_txn("sh_3001", `SH, 32'h3001, 32'h1234,    5'd14, 0, 0, 32'h0);
      run_txn("lh_3003", `LH, 32'h3003, 32'h0,       5'd15, 1, 1, 32'h8001_7FFF);
   endtask

   task automatic test_reset_in_rwait;
      @(negedge clk_in);
      mem_op_in = `LW; mem_addr_in = 32'h40; reg_waddr_in = 5'd20; reg_we_in = 1'b0; reg_wdata_in = 0;
      bus_gnt_in = 1'b1; bus_rvalid_in = 1'b0; bus_rdata_in = 32'h1111_2222;
      @(negedge clk_in);
      mem_op_in = `MEM_NOP; bus_gnt_in = 1'b0;
      #1;
      checks++;
      if (stall_out !== 1'b1) begin
         errors++; $display("FAIL rwait stall got %b want 1", stall_out);
      end
      reset_in = 1'b0;
      #1;
      checks++;
      if ({bus_req_out, bus_be_out, stall_out, reg_we_out, reg_wdata_out, misalign_out} !== '0) begin
         errors++; $display("FAIL async reset req=%b be=%b stall=%b reg_we=%b want 0", bus_req_out, bus_be_out, stall_out, reg_we_out);
      end
      @(negedge clk_in);
      reset_in = 1'b1; bus_rvalid_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in); #1;
         checks++;
         if ({bus_req_out, stall_out, reg_we_out, reg_wdata_out, misalign_out} !== '0) begin
            errors++; $display("FAIL post_reset%0d stale rvalid consumed reg_we=%b data=%h stall=%b want 0",
                               i, reg_we_out, reg_wdata_out, stall_out);
         end
      end
      bus_rvalid_in = 1'b0;
   endtask

   task automatic test_back_to_back;
      run_txn("b2b_sw", `SW,  32'h500, 32'hA1A2_A3A4, 5'd1, 0, 0, 32'h0);
      run_txn("b2b_lb", `LB,  32'h502, 32'h0,         5'd2, 0, 0, 32'h007F_0000);
      run_txn("b2b_sb", `SB,  32'h501, 32'h0000_00C3, 5'd3, 1, 0, 32'h0);
      run_txn("b2b_lh", `LHU, 32'h500, 32'h0,         5'd4, 0, 1, 32'h1234_FEDC);
      @(negedge clk_in); #1;
      checks++;
      if (reg_we_out !== 1'b0 || stall_out !== 1'b0) begin
         errors++; $display("FAIL b2b idle reg_we/stall got %b/%b want 0/0", reg_we_out, stall_out);
      end
   endtask

   task automatic test_random;
      logic [3:0] op;
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(8, 1));
         run_txn($sformatf("rnd%0d", i), op, $urandom, $urandom, 5'($urandom),
                 $urandom_range(3, 0), $urandom_range(3, 0), $urandom);
      end
   endtask

   initial begin
      test_reset;
      test_nop_passthrough;
      test_store_byte;
      test_load_byte;
      test_lhu_gnt_delay;
      test_lw_same_cycle;
      test_misalign;
      test_reset_in_rwait;
      test_back_to_back;
      test_random;
      @(negedge clk_in);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
